// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: nop head values and predictor metadata field layout shared by fetch and decode.
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] NOP_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_NPC = 32'h0000_0000;
  localparam logic NOP_COMMIT = 1'b0;
  localparam int FQ_HIST_W = 8;
  localparam int FQ_META_W = FQ_HIST_W + 4;
  localparam int META_TRAIN_PREDICT = 0;
  localparam int META_TRAIN_VALID = 1;
  localparam int META_HIST_LSB = 2;
  localparam int META_GLOBAL_PRED = FQ_HIST_W + 2;
  localparam int META_LOCAL_PRED = FQ_HIST_W + 3;
endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: entry storage with one synchronous write port and one asynchronous read port; not reset.
module fq_ram #(
  parameter int DEPTH = 4,
  parameter int W = 109,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_i) if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FWFT circular buffer between fetch and decode with valid/ready and flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter int HIST_W = 8,
  parameter int META_W = HIST_W + 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               F_valid_i,
  output logic               F_ready_o,
  input  logic [INSTR_W-1:0] F_instr_i,
  input  logic [PC_W-1:0]    F_PC_i,
  input  logic [PC_W-1:0]    F_nPC_i,
  input  logic               F_commit_i,
  input  logic [META_W-1:0]  F_meta_i,
  output logic               FD_valid_o,
  input  logic               D_ready_i,
  output logic [INSTR_W-1:0] FD_instr_o,
  output logic [PC_W-1:0]    FD_PC_o,
  output logic [PC_W-1:0]    FD_nPC_o,
  output logic               FD_commit_o,
  output logic [META_W-1:0]  FD_meta_o,
  output logic [CNT_W-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = INSTR_W + 2 * PC_W + 1 + META_W;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic w_full, w_empty, w_push, w_pop;
  logic [EW-1:0] w_rd_data;
  logic [INSTR_W-1:0] w_instr;
  logic [PC_W-1:0] w_pc, w_npc;
  logic w_commit;
  logic [META_W-1:0] w_meta;
  assign w_full = r_count == CNT_W'(DEPTH);
  assign w_empty = r_count == '0;
  // Ready depends only on occupancy so it never combinationally follows D_ready_i.
  assign F_ready_o = ~w_full;
  assign FD_valid_o = ~w_empty;
  assign w_push = F_valid_i & ~w_full & ~flush_i;
  assign w_pop = ~w_empty & D_ready_i & ~flush_i;
  assign count_o = r_count;
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  fq_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
    .clk_i(clk_i),
    .we(w_push),
    .waddr(r_wr_ptr),
    .wdata({F_instr_i, F_PC_i, F_nPC_i, F_commit_i, F_meta_i}),
    .raddr(r_rd_ptr),
    .rdata(w_rd_data)
  );
  assign {w_instr, w_pc, w_npc, w_commit, w_meta} = w_rd_data;
  assign FD_instr_o = w_empty ? INSTR_W'(NOP_INSTR) : w_instr;
  assign FD_PC_o = w_empty ? PC_W'(NOP_PC) : w_pc;
  assign FD_nPC_o = w_empty ? PC_W'(NOP_NPC) : w_npc;
  assign FD_commit_o = w_empty ? NOP_COMMIT : w_commit;
  assign FD_meta_o = w_empty ? '0 : w_meta;
  always @(posedge clk_i) if (!rst) assert (!(F_valid_i && F_ready_o && w_full) && !(w_pop && w_empty));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors with hand-computed expectations for fetch_queue.
module tb_fetch_queue;
  logic clk_i = 0, rst = 1, flush_i = 0, F_valid_i = 0, D_ready_i = 0, F_commit_i = 0;
  logic F_ready_o, FD_valid_o, FD_commit_o;
  logic [31:0] F_instr_i = 0, F_PC_i = 0, F_nPC_i = 0, FD_instr_o, FD_PC_o, FD_nPC_o;
  logic [11:0] F_meta_i = 0, FD_meta_o, meta_a5;
  logic [2:0] count_o;
  int n_cmp = 0, n_err = 0;
  fetch_queue dut (
    .clk_i(clk_i), .rst(rst), .flush_i(flush_i), .F_valid_i(F_valid_i), .F_ready_o(F_ready_o),
    .F_instr_i(F_instr_i), .F_PC_i(F_PC_i), .F_nPC_i(F_nPC_i), .F_commit_i(F_commit_i),
    .F_meta_i(F_meta_i), .FD_valid_o(FD_valid_o), .D_ready_i(D_ready_i), .FD_instr_o(FD_instr_o),
    .FD_PC_o(FD_PC_o), .FD_nPC_o(FD_nPC_o), .FD_commit_o(FD_commit_o), .FD_meta_o(FD_meta_o),
    .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic commit, input logic [11:0] meta);
    F_valid_i = 1; F_instr_i = instr; F_PC_i = pc; F_nPC_i = pc + 4; F_commit_i = commit; F_meta_i = meta;
    step();
    F_valid_i = 0;
  endtask
  initial begin
    meta_a5 = {1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    step(); step();
    rst = 0;
    chk("rst_valid", FD_valid_o, 0);
    chk("rst_instr", FD_instr_o, 32'h13);
    chk("rst_ready", F_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_pc", FD_PC_o, 0);
    D_ready_i = 1; step(); step();
    chk("idle_valid", FD_valid_o, 0);
    chk("idle_count", count_o, 0);
    D_ready_i = 0;
    push(32'h00000013, 32'h0, 0, 12'h000);
    push(32'h00100093, 32'h4, 1, 12'h123);
    push(32'h00200113, 32'h8, 0, 12'h456);
    chk("seq_count", count_o, 3);
    chk("seq_pc0", FD_PC_o, 32'h0);
    chk("seq_valid", FD_valid_o, 1);
    D_ready_i = 1; step();
    chk("seq_pc1", FD_PC_o, 32'h4);
    chk("seq_instr1", FD_instr_o, 32'h00100093);
    chk("seq_npc1", FD_nPC_o, 32'h8);
    chk("seq_commit1", FD_commit_o, 1);
    chk("seq_meta1", FD_meta_o, 12'h123);
    step();
    chk("seq_pc2", FD_PC_o, 32'h8);
    chk("seq_instr2", FD_instr_o, 32'h00200113);
    step();
    chk("seq_empty_valid", FD_valid_o, 0);
    chk("seq_empty_instr", FD_instr_o, 32'h13);
    chk("seq_empty_count", count_o, 0);
    D_ready_i = 0;
    for (int i = 0; i < 4; i++) push(32'hA000 + i, 32'h100 + 4 * i, 0, 12'(i));
    chk("full_count", count_o, 4);
    chk("full_ready", F_ready_o, 0);
    F_valid_i = 1; F_instr_i = 32'hBAD; F_PC_i = 32'h200; D_ready_i = 1;
    step();
    F_valid_i = 0;
    chk("full_pp_count", count_o, 3);
    chk("full_pp_ready", F_ready_o, 1);
    chk("full_pp_pc", FD_PC_o, 32'h104);
    step();
    chk("drain_pc1", FD_PC_o, 32'h108);
    step();
    chk("drain_pc2", FD_PC_o, 32'h10c);
    chk("drain_meta2", FD_meta_o, 12'h3);
    step();
    chk("drain_empty", FD_valid_o, 0);
    D_ready_i = 0;
    push(32'h1000, 32'h1000, 0, meta_a5);
    D_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      F_valid_i = 1; F_instr_i = 32'h2000 + i; F_PC_i = 32'h1004 + 4 * i; F_nPC_i = F_PC_i + 4; F_meta_i = meta_a5;
      step();
      chk("stream_count", count_o, 1);
      chk("stream_pc", FD_PC_o, 32'h1004 + 4 * i);
      chk("stream_instr", FD_instr_o, 32'h2000 + i);
      chk("stream_meta", FD_meta_o, 12'hA96);
    end
    F_valid_i = 0; step();
    chk("stream_end", FD_valid_o, 0);
    D_ready_i = 0;
    for (int i = 0; i < 3; i++) push(32'hC000 + i, 32'h300 + 4 * i, 0, 0);
    chk("flush_pre", count_o, 3);
    flush_i = 1; F_valid_i = 1; F_instr_i = 32'hDEAD; F_PC_i = 32'hDEAD;
    step();
    flush_i = 0; F_valid_i = 0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", FD_valid_o, 0);
    chk("flush_instr", FD_instr_o, 32'h13);
    step();
    chk("flush_absent", count_o, 0);
    push(32'hE000, 32'h400, 0, 0);
    chk("post_flush_pc", FD_PC_o, 32'h400);
    push(32'hE001, 32'h404, 0, 0);
    chk("arst_pre", count_o, 2);
    #3 rst = 1;
    #1;
    chk("arst_valid", FD_valid_o, 0);
    chk("arst_count", count_o, 0);
    step();
    rst = 0;
    chk("arst_ready", F_ready_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry fetch/decode pipeline register.
- Circular buffer of DEPTH entries between fetch and decode. Each entry carries the instruction, PC, nPC, commit flag and branch-predictor training metadata.
- Valid/ready handshake on both sides replaces bubble/stall, so fetch runs ahead of decode stalls.
- Synchronous flush empties the queue on redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- INSTR_W, 32, instruction width.
- PC_W, 32, PC/nPC width.
- HIST_W, 8, global history width.
- META_W, HIST_W+4, packed predictor metadata: {local_pred, global_pred, history[HIST_W], train_vaild, train_predict}.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush (mispredict/redirect); replaces F_bubble_i.
- F_valid_i  in  1  fetch presents an entry.
- F_ready_o  out  1  queue can accept; equals ~full.
- F_instr_i  in  INSTR_W  fetched instruction.
- F_PC_i  in  PC_W  PC of the instruction.
- F_nPC_i  in  PC_W  predicted next PC.
- F_commit_i  in  1  commit flag.
- F_meta_i  in  META_W  predictor training metadata.
- FD_valid_o  out  1  head entry valid (queue non-empty).
- D_ready_i  in  1  decode accepts the head this cycle; replaces ~F_stall_i.
- FD_instr_o  out  INSTR_W  head instruction.
- FD_PC_o  out  PC_W  head PC.
- FD_nPC_o  out  PC_W  head nPC.
- FD_commit_o  out  1  head commit flag.
- FD_meta_o  out  META_W  head metadata.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous on rst (active-high), one clock domain, clk_i.
- Reset clears rd_ptr, wr_ptr and count to 0. Storage array is not reset.
- After reset: FD_valid_o=0, F_ready_o=1, count_o=0, and FD_* show nop values (`nop_instr, `nop_PC, `nop_nPC, `nop_commit, meta=0).
- push = F_valid_i & F_ready_o; pop = FD_valid_o & D_ready_i.
- On push, the entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- On pop, rd_ptr increments modulo DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
- full = (count==DEPTH); empty = (count==0).
- Head outputs are first-word-fall-through, driven combinationally from entry[rd_ptr].
- When empty, head outputs are forced to the nop values and FD_valid_o=0. Decode therefore never sees stale data.
- Latency: an entry pushed at edge N is visible on FD_* immediately after edge N (one-cycle register latency, same as the old stage). There is no same-cycle bypass from F_* to FD_*.
- Full: F_ready_o=0 even if a pop occurs the same cycle. No push-through when full; this keeps ready off the decode path.
- Empty with D_ready_i=1: no pop; pointers unchanged.
- Simultaneous push and pop at count 1: head advances to the new entry, count stays 1.
- flush_i=1 at an edge:
  - rd_ptr, wr_ptr and count go to 0.
  - Any push or pop in that cycle is discarded.
  - The next cycle shows empty/nop.
  - flush has priority over push and pop.
- F_ready_o is not gated by flush_i. Fetch treats its flush-cycle output as dropped.
- rst asserted mid-operation: the queue empties immediately (asynchronous); in-flight entries are lost.
- All FD_* fields of one entry are always from the same push; no field mixing.
- No overflow or underflow is possible by construction. An assertion flags push while full and pop while empty.

Decomposition:
- Shared `define.v` already holds the nop constants and `history_WIDTH`. Add `fq_meta_width` = `history_WIDTH`+4, and the meta field bit positions, so fetch and decode pack and unpack identically.
- One natural sub-module: fq_ram, a DEPTH x (INSTR_W+2*PC_W+1+META_W) register array with one synchronous write port and one asynchronous read port.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset then idle, with D_ready_i=1 -> FD_valid_o=0, FD_instr_o=`nop_instr, F_ready_o=1, count_o=0.
- Push instructions 0x00000013, 0x00100093, 0x00200113 at PCs 0x0, 0x4, 0x8 with D_ready_i=0 -> count_o=3, FD_PC_o=0x0. Then D_ready_i=1 -> FD_PC_o sequence 0x4, 0x8, then empty/nop.
- Fill DEPTH=4 entries -> F_ready_o=0. Push+pop same cycle while full -> push refused, count_o=3. Next cycle F_ready_o=1.
- Continuous push and pop for 10 cycles with PC stepping by 4 -> count_o stays 1, outputs in order, pointers wrap past 3->0 without corruption, meta delivered unchanged (e.g. 0xA5 history).
- count_o=3 with flush_i=1 and F_valid_i=1 in the same cycle -> next cycle count_o=0, FD_valid_o=0, pushed entry absent.
- rst asserted asynchronously between edges with count_o=2 -> FD_valid_o=0 and count_o=0 before the next clk_i edge.
